// File: rtl/uart_rx.sv
`timescale 1ns/1ps
// uart_rx: 8N1 serial receiver with valid/read handshake, sticky framing and
// overrun flags. Define UART_RX_PARITY_EN for 8E1 frames with a sticky
// parity-error flag; without it the frame is 8N1 and URX_PErr reads 0.
module uart_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       clk,
  input  logic       Rst,
  input  logic       URX_SIn,
  input  logic       URX_Rd,
  output logic [7:0] URX_Data,
  output logic       URX_Valid,
  output logic       URX_Busy,
  output logic       URX_FErr,
  output logic       URX_OErr,
  output logic       URX_PErr
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    BRK
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   clk_cnt, clk_cnt_nxt;
  logic [2:0]      bit_cnt, bit_cnt_nxt;
  logic [7:0]      shift, shift_nxt;
  logic            rx_meta, rx_s;
  logic [7:0]      data_q;
  logic            valid_q, ferr_q, oerr_q;
  logic            frame_ok, set_ferr;

`ifdef UART_RX_PARITY_EN
  logic            set_perr, perr_q;

  // Even parity: data plus parity bit must hold an even number of ones.
  function automatic logic parity_err(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction
`endif

  // Two-flop synchronizer; idles high so reset never looks like a start bit.
  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= URX_SIn;
      rx_s    <= rx_meta;
    end
  end

  // Frame FSM state and bit-timing counters.
  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      state   <= IDLE;
      clk_cnt <= '0;
      bit_cnt <= '0;
      shift   <= '0;
    end else begin
      state   <= state_nxt;
      clk_cnt <= clk_cnt_nxt;
      bit_cnt <= bit_cnt_nxt;
      shift   <= shift_nxt;
    end
  end

  // Next-state logic: mid-bit sampling after the start-bit half period.
  always_comb begin
    state_nxt   = state;
    clk_cnt_nxt = clk_cnt;
    bit_cnt_nxt = bit_cnt;
    shift_nxt   = shift;
    frame_ok    = 1'b0;
    set_ferr    = 1'b0;
`ifdef UART_RX_PARITY_EN
    set_perr    = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_nxt   = START;
          clk_cnt_nxt = '0;
          bit_cnt_nxt = '0;
        end
      end
      START: begin
        if (clk_cnt == HALF_LAST) begin
          clk_cnt_nxt = '0;
          state_nxt   = rx_s ? IDLE : DATA;
        end else begin
          clk_cnt_nxt = clk_cnt + CW'(1);
        end
      end
      DATA: begin
        if (clk_cnt == FULL_LAST) begin
          clk_cnt_nxt = '0;
          shift_nxt   = {rx_s, shift[7:1]};
          bit_cnt_nxt = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end
        end else begin
          clk_cnt_nxt = clk_cnt + CW'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (clk_cnt == FULL_LAST) begin
          clk_cnt_nxt = '0;
          set_perr    = parity_err(shift, rx_s);
          state_nxt   = STOP;
        end else begin
          clk_cnt_nxt = clk_cnt + CW'(1);
        end
      end
`endif
      STOP: begin
        if (clk_cnt == FULL_LAST) begin
          clk_cnt_nxt = '0;
          if (rx_s) begin
            frame_ok  = 1'b1;
            state_nxt = IDLE;
          end else begin
            set_ferr  = 1'b1;
            state_nxt = BRK;
          end
        end else begin
          clk_cnt_nxt = clk_cnt + CW'(1);
        end
      end
      BRK: begin
        // Line held low after a bad stop bit: wait for it to return high.
        if (rx_s) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output byte, handshake and sticky error flags.
  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      oerr_q  <= 1'b0;
    end else begin
      // A read in the completion cycle frees the holding register in time.
      if (frame_ok && (!valid_q || URX_Rd)) data_q <= shift;
      if (frame_ok)    valid_q <= 1'b1;
      else if (URX_Rd) valid_q <= 1'b0;
      ferr_q <= set_ferr | (ferr_q & ~URX_Rd);
      oerr_q <= (frame_ok & valid_q & ~URX_Rd) | (oerr_q & ~URX_Rd);
    end
  end

`ifdef UART_RX_PARITY_EN
  // Sticky parity error; the byte is still delivered on a parity failure.
  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) perr_q <= 1'b0;
    else      perr_q <= set_perr | (perr_q & ~URX_Rd);
  end
  assign URX_PErr = perr_q;
`else
  assign URX_PErr = 1'b0;
`endif

  assign URX_Data  = data_q;
  assign URX_Valid = valid_q;
  assign URX_Busy  = (state != IDLE);
  assign URX_FErr  = ferr_q;
  assign URX_OErr  = oerr_q;

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
// tb_uart_rx: directed frames against the UART receiver with hand-computed
// expected bytes and flag states.
module tb_uart_rx;

  localparam int CPB  = 16;
  localparam int HALF = 8;
`ifdef UART_RX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  // Stimulus iteration whose read strobe lands on the stop-bit sample edge:
  // 2 sync flops + 1 idle-detect edge + half bit + (NB-1) full bits.
  localparam int RD_AT = 3 + HALF + (NB - 1) * CPB - 1;

  logic       clk = 1'b0;
  logic       Rst;
  logic       URX_SIn;
  logic       URX_Rd;
  logic [7:0] URX_Data;
  logic       URX_Valid;
  logic       URX_Busy;
  logic       URX_FErr;
  logic       URX_OErr;
  logic       URX_PErr;

  int total = 0;
  int bad   = 0;
  logic busy_seen;

  always #5 clk = ~clk;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .Rst       (Rst),
    .URX_SIn   (URX_SIn),
    .URX_Rd    (URX_Rd),
    .URX_Data  (URX_Data),
    .URX_Valid (URX_Valid),
    .URX_Busy  (URX_Busy),
    .URX_FErr  (URX_FErr),
    .URX_OErr  (URX_OErr),
    .URX_PErr  (URX_PErr)
  );

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rd_pulse();
    URX_Rd = 1'b1;
    tick(1);
    URX_Rd = 1'b0;
  endtask

  // One frame, LSB first; rd_at raises URX_Rd for one chosen iteration.
  task automatic send_frame(input logic [7:0] b, input logic par, input logic stop, input int rd_at);
    logic [10:0] bits;
`ifdef UART_RX_PARITY_EN
    bits = {stop, par, b, 1'b0};
`else
    bits = {1'b1, stop, b, 1'b0};
`endif
    for (int i = 0; i < NB * CPB; i++) begin
      URX_SIn = bits[i / CPB];
      URX_Rd  = (i == rd_at);
      tick(1);
    end
    URX_Rd = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Rst = 1'b0; URX_SIn = 1'b1; URX_Rd = 1'b0;
    tick(3);
    chk("rst_data",  URX_Data,       8'h00);
    chk("rst_valid", 8'(URX_Valid),  8'd0);
    chk("rst_busy",  8'(URX_Busy),   8'd0);
    chk("rst_ferr",  8'(URX_FErr),   8'd0);
    chk("rst_oerr",  8'(URX_OErr),   8'd0);
    chk("rst_perr",  8'(URX_PErr),   8'd0);
    Rst = 1'b1;
    tick(2);

    // Reset in the middle of a frame
    URX_SIn = 1'b0;
    tick(40);
    chk("mid_busy", 8'(URX_Busy), 8'd1);
    Rst = 1'b0;
    #1;
    chk("mid_rst_busy",  8'(URX_Busy),  8'd0);
    chk("mid_rst_valid", 8'(URX_Valid), 8'd0);
    URX_SIn = 1'b1;
    tick(3);
    Rst = 1'b1;

    // Idle line
    busy_seen = 1'b0;
    for (int i = 0; i < 500; i++) begin
      tick(1);
      if (URX_Busy) busy_seen = 1'b1;
    end
    chk("idle_busy",  8'(busy_seen), 8'd0);
    chk("idle_valid", 8'(URX_Valid), 8'd0);
    chk("idle_data",  URX_Data,      8'h00);
    chk("idle_ferr",  8'(URX_FErr),  8'd0);

    // Single frame 0xA5
    send_frame(8'hA5, 1'b0, 1'b1, -1);
    chk("a5_valid", 8'(URX_Valid), 8'd1);
    chk("a5_data",  URX_Data,      8'hA5);
    chk("a5_ferr",  8'(URX_FErr),  8'd0);
    chk("a5_busy",  8'(URX_Busy),  8'd0);
    rd_pulse();
    chk("a5_rd_valid", 8'(URX_Valid), 8'd0);
    chk("a5_rd_data",  URX_Data,      8'hA5);

    // Read with nothing held
    rd_pulse();
    chk("idle_rd_valid", 8'(URX_Valid), 8'd0);

    // Overrun: second byte dropped
    send_frame(8'h3C, 1'b0, 1'b1, -1);
    send_frame(8'hC3, 1'b0, 1'b1, -1);
    chk("ovr_data",  URX_Data,      8'h3C);
    chk("ovr_valid", 8'(URX_Valid), 8'd1);
    chk("ovr_oerr",  8'(URX_OErr),  8'd1);
    rd_pulse();
    chk("ovr_rd_oerr",  8'(URX_OErr),  8'd0);
    chk("ovr_rd_valid", 8'(URX_Valid), 8'd0);

    // Read coincident with frame completion
    send_frame(8'h11, 1'b0, 1'b1, -1);
    chk("co_first", URX_Data, 8'h11);
    send_frame(8'h22, 1'b1, 1'b1, RD_AT);
    chk("co_valid", 8'(URX_Valid), 8'd1);
    chk("co_data",  URX_Data,      8'h22);
    chk("co_oerr",  8'(URX_OErr),  8'd0);
    rd_pulse();

    // Framing error followed by a held-low line
    send_frame(8'h55, 1'b0, 1'b0, -1);
    tick(40);
    chk("fe_ferr",  8'(URX_FErr),  8'd1);
    chk("fe_valid", 8'(URX_Valid), 8'd0);
    chk("fe_busy",  8'(URX_Busy),  8'd1);
    URX_SIn = 1'b1;
    tick(20);
    chk("fe_hi_busy",  8'(URX_Busy),  8'd0);
    chk("fe_hi_valid", 8'(URX_Valid), 8'd0);
    send_frame(8'h0F, 1'b0, 1'b1, -1);
    chk("fe_next_valid", 8'(URX_Valid), 8'd1);
    chk("fe_next_data",  URX_Data,      8'h0F);
    chk("fe_sticky",     8'(URX_FErr),  8'd1);
    rd_pulse();
    chk("fe_rd_ferr", 8'(URX_FErr), 8'd0);

    // Start-bit glitch shorter than half a bit
    URX_SIn = 1'b0;
    tick(5);
    URX_SIn = 1'b1;
    tick(30);
    chk("gl_valid", 8'(URX_Valid), 8'd0);
    chk("gl_busy",  8'(URX_Busy),  8'd0);
    chk("gl_ferr",  8'(URX_FErr),  8'd0);
    chk("gl_oerr",  8'(URX_OErr),  8'd0);
    chk("gl_perr",  8'(URX_PErr),  8'd0);

`ifdef UART_RX_PARITY_EN
    // 0x07 has three ones: even parity needs a 1
    send_frame(8'h07, 1'b0, 1'b1, -1);
    chk("par_bad_data",  URX_Data,      8'h07);
    chk("par_bad_valid", 8'(URX_Valid), 8'd1);
    chk("par_bad_perr",  8'(URX_PErr),  8'd1);
    rd_pulse();
    chk("par_rd_perr", 8'(URX_PErr), 8'd0);
    send_frame(8'h07, 1'b1, 1'b1, -1);
    chk("par_ok_data", URX_Data,     8'h07);
    chk("par_ok_perr", 8'(URX_PErr), 8'd0);
    rd_pulse();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
